// File: rtl/lcd_bus_writer_if.sv
// Command/data word stream feeding the LCD bus writer.
// The producer drives data/dc/valid and the writer answers with ready.
interface lcd_bus_writer_if #(
    parameter int DataWidth = 18
);
    logic [DataWidth-1:0] in_data;
    logic                 in_dc;
    logic                 in_valid;
    logic                 in_ready;

    modport master (
        output in_data,
        output in_dc,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_dc,
        input  in_valid,
        output in_ready
    );
endinterface : lcd_bus_writer_if

// File: rtl/lcd_bus_writer.sv
// 8080-style write-only LCD bus serialiser with panel hardware-reset sequencing.
// Define LCD_BUS_WRITER_FIFO_EN to add a FifoDepth-entry input FIFO (default: single holding register).
module lcd_bus_writer #(
    parameter int DataWidth       = 18,
    parameter int StrobeCount     = 2,
    parameter int HoldCount       = 2,
    parameter int ResetTimerCount = 100,
    parameter int FifoDepth       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lcd_bus_writer_if.slave      in_if,
    input  logic                 panel_reset_request_i,
    input  logic                 backlight_i,
    output logic                 busy_o,
    output logic [DataWidth-1:0] lcd_db_o,
    output logic                 lcd_wr_o,
    output logic                 lcd_rd_o,
    output logic                 lcd_rs_o,
    output logic                 lcd_cs_o,
    output logic                 lcd_rst_o,
    output logic                 lcd_blen_o
);

    localparam int MaxCount =
        (ResetTimerCount > StrobeCount)
            ? ((ResetTimerCount > HoldCount) ? ResetTimerCount : HoldCount)
            : ((StrobeCount > HoldCount) ? StrobeCount : HoldCount);
    localparam int CntW = (MaxCount > 1) ? $clog2(MaxCount) : 1;

    localparam logic [CntW-1:0] RstLast    = CntW'(ResetTimerCount - 1);
    localparam logic [CntW-1:0] StrobeLast = CntW'(StrobeCount - 1);
    localparam logic [CntW-1:0] HoldLast   = CntW'(HoldCount - 1);

    if (StrobeCount < 1 || HoldCount < 1 || ResetTimerCount < 1 ||
        FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_param_check
        $error("lcd_bus_writer: illegal parameter set");
    end

    typedef enum logic [2:0] {
        RST_ASSERT,
        RST_RECOVER,
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 req_q, req_d;
    logic                 cs_q, cs_d;
    logic                 wr_q, wr_d;
    logic                 rs_q, rs_d;
    logic [DataWidth-1:0] db_q, db_d;
    logic                 rst_q, rst_d;
    logic                 blen_q;

    logic                 req_any;
    logic                 base_ready;
    logic                 in_ready;
    logic                 accept;
    logic                 queue_empty;
    logic                 have_word;
    logic                 src_dc;
    logic [DataWidth-1:0] src_data;

    // A request seen this very cycle already blocks acceptance.
    assign req_any   = req_q | panel_reset_request_i;
    assign in_ready  = base_ready & ~req_any;
    assign accept    = in_if.in_valid & in_ready;
    assign have_word = accept | ~queue_empty;

`ifdef LCD_BUS_WRITER_FIFO_EN
    localparam int AddrW = $clog2(FifoDepth);

    logic [DataWidth:0] mem_q [FifoDepth];
    logic [AddrW:0]     wr_ptr_q, rd_ptr_q;
    logic [DataWidth:0] head;
    logic               fifo_empty, fifo_full;
    logic               launch, flush, push, pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                        (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign head       = mem_q[rd_ptr_q[AddrW-1:0]];

    // An empty FIFO is bypassed so a lone word still reaches SETUP one cycle after acceptance.
    assign launch = (state_d == SETUP);
    assign flush  = (state_d == RST_ASSERT);
    assign pop    = launch & ~fifo_empty;
    assign push   = accept & ~(launch & fifo_empty);

    assign queue_empty = fifo_empty;
    assign base_ready  = ~fifo_full && (state_q != RST_ASSERT) && (state_q != RST_RECOVER);
    assign src_dc      = fifo_empty ? in_if.in_dc   : head[DataWidth];
    assign src_data    = fifo_empty ? in_if.in_data : head[DataWidth-1:0];

    // NOTE: storage arrays carry no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= {in_if.in_dc, in_if.in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AddrW + 1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AddrW + 1)'(1);
        end
    end
`else
    // The bus registers double as the single holding register.
    assign queue_empty = 1'b1;
    assign base_ready  = (state_q == IDLE) || (state_q == HOLD && cnt_q == HoldLast);
    assign src_dc      = in_if.in_dc;
    assign src_data    = in_if.in_data;
`endif

    always_comb begin
        // NOTE: every signal gets a default up front so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        cs_d    = cs_q;
        wr_d    = wr_q;
        rs_d    = rs_q;
        db_d    = db_q;
        rst_d   = rst_q;

        unique case (state_q)
            RST_ASSERT: begin
                if (panel_reset_request_i) begin
                    cnt_d = '0;
                end else if (cnt_q == RstLast) begin
                    state_d = RST_RECOVER;
                    cnt_d   = '0;
                    rst_d   = 1'b1;
                end
            end
            RST_RECOVER: begin
                if (panel_reset_request_i) begin
                    state_d = RST_ASSERT;
                    cnt_d   = '0;
                    rst_d   = 1'b0;
                end else if (cnt_q == RstLast) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (req_any) begin
                    state_d = RST_ASSERT;
                    cnt_d   = '0;
                    rst_d   = 1'b0;
                end else if (have_word) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    cs_d    = 1'b0;
                    rs_d    = src_dc;
                    db_d    = src_data;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = '0;
                wr_d    = 1'b0;
            end
            STROBE: begin
                if (cnt_q == StrobeLast) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    wr_d    = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HoldLast) begin
                    cnt_d = '0;
                    if (req_any) begin
                        state_d = RST_ASSERT;
                        cs_d    = 1'b1;
                        rst_d   = 1'b0;
                    end else if (have_word) begin
                        // Back-to-back: chip select stays low across the word boundary.
                        state_d = SETUP;
                        rs_d    = src_dc;
                        db_d    = src_data;
                    end else begin
                        state_d = IDLE;
                        cs_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RST_ASSERT;
                cnt_d   = '0;
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                rst_d   = 1'b0;
            end
        endcase

        // The latch clears as soon as the reset sequence (re)starts.
        req_d = req_any & (state_d != RST_ASSERT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_ASSERT;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            rs_q    <= 1'b0;
            db_q    <= '0;
            rst_q   <= 1'b0;
            blen_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            rst_q   <= rst_d;
            blen_q  <= backlight_i;
        end
    end

    assign in_if.in_ready = in_ready;
    assign busy_o         = (state_q != IDLE) | ~queue_empty | req_q;
    assign lcd_db_o       = db_q;
    assign lcd_wr_o       = wr_q;
    assign lcd_rd_o       = 1'b1;
    assign lcd_rs_o       = rs_q;
    assign lcd_cs_o       = cs_q;
    assign lcd_rst_o      = rst_q;
    assign lcd_blen_o     = blen_q;

endmodule : lcd_bus_writer
